// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with registered one-hot grant,
// binary grant index, and an optional per-grant hold limit that forces
// release (flagged by a one-cycle 'expired' pulse).
module rr_arbiter16 #(
  parameter int N_REQ    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic               done,
  output logic [N_REQ-1:0]   gnt,
  output logic [3:0]         gnt_idx,
  output logic               gnt_valid,
  output logic               expired
);

  localparam int IDX_W = 4;
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               expired_q, expired_d;

  // Requests rotated so that bit 0 is the current highest-priority requester.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   pick_off;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_q +: N_REQ];

  // Lowest set bit of the rotated vector is the first requester in search order.
  always_comb begin
    pick_off   = '0;
    pick_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_off   = IDX_W'(i);
        pick_found = 1'b1;
      end
    end
  end

  // Undo the rotation; the 4-bit add wraps modulo 16.
  assign pick_idx = ptr_q + pick_off;

  // Release conditions for the current owner.
  logic hold_hit;
  logic owner_req;
  logic release_now;

  assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);
  assign owner_req   = req[gnt_idx_q];
  assign release_now = done | ~owner_req | hold_hit;

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    expired_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          gnt_idx_d  = pick_idx;
          hold_cnt_d = 8'd1;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d     = '0;
          gnt_idx_d = '0;
          ptr_d     = gnt_idx_q + IDX_W'(1);
          // Only a release caused purely by the hold limit counts as expiry.
          expired_d = hold_hit & ~done & owner_req;
          state_d   = IDLE;
        end else if (hold_cnt_q != 8'hFF) begin
          // Saturate so an unlimited grant never wraps the counter.
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      expired_q  <= expired_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed testbench for rr_arbiter16. Main instance uses MAX_HOLD=4; a
// second instance with MAX_HOLD=0 shares the stimulus to cover the
// unlimited-hold case.
module tb_rr_arbiter16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;

  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        expired;

  logic [15:0] gnt0;
  logic [3:0]  gnt_idx0;
  logic        gnt_valid0;
  logic        expired0;

  int total;
  int bad;

  rr_arbiter16 #(.N_REQ(16), .MAX_HOLD(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .expired   (expired)
  );

  rr_arbiter16 #(.N_REQ(16), .MAX_HOLD(0)) u_dut_nolim (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt0),
    .gnt_idx   (gnt_idx0),
    .gnt_valid (gnt_valid0),
    .expired   (expired0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] eg, input logic [3:0] ei,
                         input logic ev, input logic ee);
    chk({tag, ".gnt"},     32'(gnt),       32'(eg));
    chk({tag, ".idx"},     32'(gnt_idx),   32'(ei));
    chk({tag, ".valid"},   32'(gnt_valid), 32'(ev));
    chk({tag, ".expired"}, 32'(expired),   32'(ee));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0]  wrap_seq [4];
  logic        exp_seen;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    wrap_seq[0] = 4'd0;
    wrap_seq[1] = 4'd15;
    wrap_seq[2] = 4'd0;
    wrap_seq[3] = 4'd15;

    // Reset state.
    tick();
    tick();
    chk_out("reset", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Single request, then done.
    rst_n = 1'b1;
    req   = 16'h0001;
    tick();
    chk_out("single.grant", 16'h0001, 4'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_out("single.release", 16'h0000, 4'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = 16'h0000;
    // done while idle is ignored.
    done = 1'b1;
    tick();
    chk_out("idle.done", 16'h0000, 4'd0, 1'b0, 1'b0);
    done = 1'b0;

    // Rotation and wrap with 0x8001, done on each grant's 2nd cycle.
    do_reset();
    req = 16'h8001;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk_out($sformatf("wrap%0d.c1", g), 16'h0001 << wrap_seq[g], wrap_seq[g], 1'b1, 1'b0);
      tick();
      chk($sformatf("wrap%0d.c2", g), 32'(gnt_idx), 32'(wrap_seq[g]));
      done = 1'b1;
      tick();
      chk($sformatf("wrap%0d.dead", g), 32'(gnt), 32'h0);
      done = 1'b0;
    end

    // Full fairness: 0xFFFF with done on every grant cycle; ptr is 0 here.
    req = 16'hFFFF;
    for (int g = 0; g < 17; g++) begin
      tick();
      chk($sformatf("fair%0d.gnt", g), 32'(gnt), 32'(16'h0001 << (g % 16)));
      chk($sformatf("fair%0d.idx", g), 32'(gnt_idx), 32'(g % 16));
      done = 1'b1;
      tick();
      chk($sformatf("fair%0d.dead", g), 32'(gnt), 32'h0);
      done = 1'b0;
    end
    req = 16'h0000;

    // Hold limit of 4 with a single persistent requester.
    do_reset();
    req = 16'h0004;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk_out($sformatf("hold.c%0d", c), 16'h0004, 4'd2, 1'b1, 1'b0);
    end
    tick();
    chk_out("hold.expire", 16'h0000, 4'd0, 1'b0, 1'b1);
    chk("nolim.held", 32'(gnt0), 32'h0004);
    chk("nolim.noexp", 32'(expired0), 32'h0);
    tick();
    chk_out("hold.regrant", 16'h0004, 4'd2, 1'b1, 1'b0);
    // Unlimited instance must hold through counter saturation.
    exp_seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      exp_seen = exp_seen | expired0 | ~gnt_valid0;
    end
    chk("nolim.sat.noexp_nodrop", 32'(exp_seen), 32'h0);
    chk("nolim.sat.gnt", 32'(gnt0), 32'h0004);
    chk("nolim.sat.idx", 32'(gnt_idx0), 32'h2);

    // Expired requester loses to another pending requester.
    do_reset();
    req = 16'h0004;
    for (int c = 0; c < 4; c++) tick();
    req = 16'h0006;
    tick();
    chk("hold2.expire", 32'(expired), 32'h1);
    tick();
    chk("hold2.other_wins", 32'(gnt_idx), 32'h1);
    req = 16'h0000;

    // Request drop releases without expiry; next requester after dead cycle.
    do_reset();
    req = 16'h0030;
    tick();
    chk_out("drop.grant4", 16'h0010, 4'd4, 1'b1, 1'b0);
    req = 16'h0020;
    tick();
    chk_out("drop.release", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    chk_out("drop.grant5", 16'h0020, 4'd5, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 16'h0000;

    // done coinciding with the hold limit: one release, no expiry, one ptr step.
    do_reset();
    req = 16'h0004;
    for (int c = 0; c < 4; c++) tick();
    chk("coinc.c4", 32'(gnt), 32'h0004);
    done = 1'b1;
    tick();
    chk_out("coinc.release", 16'h0000, 4'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = 16'h000C;
    tick();
    chk_out("coinc.ptr3", 16'h0008, 4'd3, 1'b1, 1'b0);
    req = 16'h0000;

    // Reset mid-grant, then ptr back to 0.
    do_reset();
    req = 16'h0100;
    tick();
    chk_out("midrst.grant8", 16'h0100, 4'd8, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_out("midrst.reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 16'h0101;
    tick();
    chk_out("midrst.grant0", 16'h0001, 4'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
